execute_stage: RTL and testbench

- Pipeline EX stage of the 5-stage CPU: integer ALU, operand-forwarding unit and the EX/MEM pipeline register in one block.
- Sits between the ID/EX register (control, register operands, immediate, rs/rt/rd) and the memory-access stage.
- Resolves RAW hazards by forwarding from EX/MEM (its own registered result) and MEM/WB (write-back data).

---
 rtl/execute_stage_if.sv | 60 ++++++
 rtl/execute_stage.sv | 161 ++++++++++++++++
 tb/tb_execute_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// -----------------------------------------------------------------------------
// execute_stage_if
//   Bundles the ID/EX-side inputs, the MEM/WB forwarding inputs and the
//   registered EX/MEM outputs of the execute stage.
//
//   Signals (direction as seen by the execute stage, modport slave):
//     writeBackControlIn  in   2       WB control, bit1 = RegWrite
//     memAccessControlIn  in   2       MEM control, passed through
//     calculationControl  in   4       [3]=RegDst [2:1]=AluOp [0]=AluSrc
//     readData1/2         in   DATA_W  rs / rt register values
//     immediateOperand    in   DATA_W  sign-extended immediate, [5:0]=funct
//     rs, rt, rdIn        in   REG_W   ID/EX register numbers
//     memWbRegWrite       in   1       MEM/WB RegWrite
//     memWbRd             in   REG_W   MEM/WB destination
//     memWbData           in   DATA_W  MEM/WB write-back data
//     writeBackControlOut out  2       registered WB control
//     memAccessControlOut out  2       registered MEM control
//     result              out  DATA_W  registered ALU result
//     writeData           out  DATA_W  registered forwarded rt (store data)
//     rdOut               out  REG_W   registered destination register
//
//   modport master: the upstream pipeline (drives ID/EX and MEM/WB signals).
//   modport slave : the execute stage.
// -----------------------------------------------------------------------------
interface execute_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic [1:0]        writeBackControlIn;
  logic [1:0]        memAccessControlIn;
  logic [3:0]        calculationControl;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] immediateOperand;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rdIn;
  logic              memWbRegWrite;
  logic [REG_W-1:0]  memWbRd;
  logic [DATA_W-1:0] memWbData;
  logic [1:0]        writeBackControlOut;
  logic [1:0]        memAccessControlOut;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] writeData;
  logic [REG_W-1:0]  rdOut;

  modport master (
    output writeBackControlIn, memAccessControlIn, calculationControl,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           memWbRegWrite, memWbRd, memWbData,
    input  writeBackControlOut, memAccessControlOut, result, writeData, rdOut
  );

  modport slave (
    input  writeBackControlIn, memAccessControlIn, calculationControl,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           memWbRegWrite, memWbRd, memWbData,
    output writeBackControlOut, memAccessControlOut, result, writeData, rdOut
  );
endinterface

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   EX stage of a 5-stage CPU: operand forwarding, integer ALU and the EX/MEM
//   pipeline register. The EX/MEM register updates on the falling edge of clk.
//
//   Ports:
//     clk    in  1   clock (EX/MEM register captures on negedge)
//     rst_n  in  1   asynchronous active-low reset, clears all outputs
//     ex     execute_stage_if.slave  ID/EX inputs, MEM/WB forwarding inputs
//                                    and registered EX/MEM outputs
//
//   Optional feature macro: EX_SHIFT_EN
//     defined   : funct 0x00/0x02/0x03 perform sll/srl/sra by operand2[4:0]
//     undefined : no shifter; those funct codes give 0 like unknown codes
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic           clk,
  input logic           rst_n,
  execute_stage_if.slave ex
);

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;

  // Forwarding mux for one operand. EX/MEM wins over MEM/WB because it holds
  // the younger instruction's value; register 0 is hard-wired and never
  // forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_W-1:0]  src,
    input logic [DATA_W-1:0] reg_val,
    input logic              exmem_wr,
    input logic [REG_W-1:0]  exmem_rd,
    input logic [DATA_W-1:0] exmem_val,
    input logic              memwb_wr,
    input logic [REG_W-1:0]  memwb_rd,
    input logic [DATA_W-1:0] memwb_val
  );
    logic [DATA_W-1:0] sel;
    sel = reg_val;
    if (exmem_wr && (exmem_rd != '0) && (exmem_rd == src)) begin
      sel = exmem_val;
    end else if (memwb_wr && (memwb_rd != '0) && (memwb_rd == src)) begin
      sel = memwb_val;
    end
    return sel;
  endfunction

  function automatic logic [DATA_W-1:0] flag_word(input logic flag);
    return {{(DATA_W-1){1'b0}}, flag};
  endfunction

  // R-type function decode. Arithmetic wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] alu_funct(
    input logic [5:0]               funct,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] y;
    y = '0;
    case (funct)
      FN_ADD:  y = a + b;
      FN_SUB:  y = a - b;
      FN_AND:  y = a & b;
      FN_OR:   y = a | b;
      FN_XOR:  y = a ^ b;
      FN_NOR:  y = ~(a | b);
      FN_SLT:  y = flag_word(a < b);
      FN_SLTU: y = flag_word($unsigned(a) < $unsigned(b));
`ifdef EX_SHIFT_EN
      FN_SLL:  y = $unsigned(a) << b[4:0];
      FN_SRL:  y = $unsigned(a) >> b[4:0];
      FN_SRA:  y = $unsigned(a >>> b[4:0]);
`else
      FN_SLL, FN_SRL, FN_SRA: y = '0;
`endif
      default: y = '0;
    endcase
    return y;
  endfunction

  function automatic logic [DATA_W-1:0] alu_op(
    input logic [1:0]               op,
    input logic [5:0]               funct,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] y;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      default: y = alu_funct(funct, a, b);
    endcase
    return y;
  endfunction

  logic                     reg_dst_p0;
  logic [1:0]               alu_op_p0;
  logic                     alu_src_p0;
  logic [DATA_W-1:0]        fwd_a_p0;
  logic [DATA_W-1:0]        fwd_b_p0;
  logic signed [DATA_W-1:0] operand1_p0;
  logic signed [DATA_W-1:0] operand2_p0;
  logic [DATA_W-1:0]        alu_out_p0;
  logic [REG_W-1:0]         rd_sel_p0;

  // ---- stage p0: forwarding, operand select, ALU (combinational) ----
  assign reg_dst_p0 = ex.calculationControl[3];
  assign alu_op_p0  = ex.calculationControl[2:1];
  assign alu_src_p0 = ex.calculationControl[0];

  // Both forwarding sources come from already-registered values (our own
  // EX/MEM outputs and the MEM/WB inputs), so there is no combinational loop.
  always_comb begin
    fwd_a_p0 = fwd_sel(ex.rs, ex.readData1,
                       ex.writeBackControlOut[1], ex.rdOut, ex.result,
                       ex.memWbRegWrite, ex.memWbRd, ex.memWbData);
    fwd_b_p0 = fwd_sel(ex.rt, ex.readData2,
                       ex.writeBackControlOut[1], ex.rdOut, ex.result,
                       ex.memWbRegWrite, ex.memWbRd, ex.memWbData);
  end

  assign operand1_p0 = $signed(fwd_a_p0);
  assign operand2_p0 = alu_src_p0 ? $signed(ex.immediateOperand) : $signed(fwd_b_p0);
  assign alu_out_p0  = alu_op(alu_op_p0, ex.immediateOperand[5:0], operand1_p0, operand2_p0);
  assign rd_sel_p0   = reg_dst_p0 ? ex.rdIn : ex.rt;

  // ---- stage p1: EX/MEM register, captured on the falling edge ----
  // Store data always takes forwarded rt, even when the ALU uses the
  // immediate, so a store sees the latest register value.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex.writeBackControlOut <= '0;
      ex.memAccessControlOut <= '0;
      ex.result              <= '0;
      ex.writeData           <= '0;
      ex.rdOut               <= '0;
    end else begin
      ex.writeBackControlOut <= ex.writeBackControlIn;
      ex.memAccessControlOut <= ex.memAccessControlIn;
      ex.result              <= alu_out_p0;
      ex.writeData           <= fwd_b_p0;
      ex.rdOut               <= rd_sel_p0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clk;
  logic rst_n;

  execute_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  execute_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  rd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one instruction for one cycle and queue what the EX/MEM register
  // must hold after the following falling edge.
  task automatic issue(
    input string       name,
    input logic [1:0]  wb,
    input logic [1:0]  mem,
    input logic [3:0]  calc,
    input logic [31:0] rd1,
    input logic [31:0] rd2,
    input logic [31:0] imm,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rdi,
    input logic        mw_we,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_data,
    input logic [31:0] e_res,
    input logic [31:0] e_wd,
    input logic [4:0]  e_rd
  );
    exp_t e;
    @(posedge clk);
    #1;
    bus.writeBackControlIn = wb;
    bus.memAccessControlIn = mem;
    bus.calculationControl = calc;
    bus.readData1          = rd1;
    bus.readData2          = rd2;
    bus.immediateOperand   = imm;
    bus.rs                 = rs;
    bus.rt                 = rt;
    bus.rdIn               = rdi;
    bus.memWbRegWrite      = mw_we;
    bus.memWbRd            = mw_rd;
    bus.memWbData          = mw_data;
    e.wb  = wb;
    e.mem = mem;
    e.res = e_res;
    e.wd  = e_wd;
    e.rd  = e_rd;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: the EX/MEM register presents a new value after every falling
  // edge; compare against the oldest outstanding expectation.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, ".result"},    bus.result, e.res);
        check({n, ".writeData"}, bus.writeData, e.wd);
        check({n, ".rdOut"},     {27'd0, bus.rdOut}, {27'd0, e.rd});
        check({n, ".ctrl"},      {28'd0, bus.writeBackControlOut, bus.memAccessControlOut},
                                 {28'd0, e.wb, e.mem});
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, ".result"},    bus.result, 32'd0);
    check({name, ".writeData"}, bus.writeData, 32'd0);
    check({name, ".rdOut"},     {27'd0, bus.rdOut}, 32'd0);
    check({name, ".ctrl"},      {28'd0, bus.writeBackControlOut, bus.memAccessControlOut}, 32'd0);
  endtask

  // calc = {RegDst, AluOp[1:0], AluSrc}
  localparam logic [3:0] C_RTYPE = 4'b1100;
  localparam logic [3:0] C_ADDI  = 4'b0001;
  localparam logic [3:0] C_SUBR  = 4'b1010;

  logic [31:0] sra_exp;
  logic [31:0] sll_exp;
  logic [31:0] srl_exp;

  initial begin
`ifdef EX_SHIFT_EN
    sra_exp = 32'hF800_0000;
    sll_exp = 32'h8000_0000;
    srl_exp = 32'h0000_0001;
`else
    sra_exp = 32'h0;
    sll_exp = 32'h0;
    srl_exp = 32'h0;
`endif
    bus.writeBackControlIn = '0;
    bus.memAccessControlIn = '0;
    bus.calculationControl = '0;
    bus.readData1          = '0;
    bus.readData2          = '0;
    bus.immediateOperand   = '0;
    bus.rs                 = '0;
    bus.rt                 = '0;
    bus.rdIn               = '0;
    bus.memWbRegWrite      = 1'b0;
    bus.memWbRd            = '0;
    bus.memWbData          = '0;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset_init");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load non-zero state, then assert reset mid-cycle.
    issue("pre_reset", 2'b10, 2'b11, C_RTYPE, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3,
          1'b0, 5'd0, 32'd0, 32'd12, 32'd7, 5'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue("add_nohaz", 2'b10, 2'b01, C_RTYPE, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3,
          1'b0, 5'd0, 32'd0, 32'd12, 32'd7, 5'd3);
    issue("fwd_exmem_a", 2'b10, 2'b00, C_RTYPE, 32'd100, 32'd2, 32'h22, 5'd3, 5'd2, 5'd6,
          1'b0, 5'd0, 32'd0, 32'd10, 32'd2, 5'd6);
    issue("add_again", 2'b10, 2'b00, C_RTYPE, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3,
          1'b0, 5'd0, 32'd0, 32'd12, 32'd7, 5'd3);
    issue("fwd_priority", 2'b10, 2'b00, C_RTYPE, 32'd100, 32'd2, 32'h22, 5'd3, 5'd2, 5'd7,
          1'b1, 5'd3, 32'd99, 32'd10, 32'd2, 5'd7);
    issue("fwd_memwb_b", 2'b10, 2'b10, C_ADDI, 32'd1, 32'h1111, 32'd8, 5'd1, 5'd4, 5'd9,
          1'b1, 5'd4, 32'h55, 32'd9, 32'h55, 5'd4);
    issue("write_r0", 2'b10, 2'b00, C_RTYPE, 32'd3, 32'd4, 32'h20, 5'd1, 5'd2, 5'd0,
          1'b0, 5'd0, 32'd0, 32'd7, 32'd4, 5'd0);
    issue("r0_guard", 2'b00, 2'b00, C_ADDI, 32'd0, 32'd0, 32'd5, 5'd0, 5'd0, 5'd12,
          1'b1, 5'd0, 32'h77, 32'd5, 32'd0, 5'd0);
    issue("slt", 2'b10, 2'b00, C_RTYPE, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd1, 5'd2, 5'd8,
          1'b0, 5'd0, 32'd0, 32'd1, 32'd1, 5'd8);
    issue("sltu", 2'b10, 2'b00, C_RTYPE, 32'hFFFF_FFFF, 32'd1, 32'h2B, 5'd1, 5'd2, 5'd9,
          1'b0, 5'd0, 32'd0, 32'd0, 32'd1, 5'd9);
    issue("nor", 2'b10, 2'b00, C_RTYPE, 32'd0, 32'd0, 32'h27, 5'd1, 5'd2, 5'd10,
          1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd10);
    issue("and", 2'b10, 2'b00, C_RTYPE, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd2, 5'd11,
          1'b0, 5'd0, 32'd0, 32'hF000, 32'hFF00, 5'd11);
    issue("or", 2'b10, 2'b00, C_RTYPE, 32'hF0F0, 32'hFF00, 32'h25, 5'd1, 5'd2, 5'd13,
          1'b0, 5'd0, 32'd0, 32'hFFF0, 32'hFF00, 5'd13);
    issue("xor", 2'b10, 2'b00, C_RTYPE, 32'hF0F0, 32'hFF00, 32'h26, 5'd1, 5'd2, 5'd14,
          1'b0, 5'd0, 32'd0, 32'h0FF0, 32'hFF00, 5'd14);
    issue("funct_unknown", 2'b10, 2'b00, C_RTYPE, 32'hF0F0, 32'hFF00, 32'h3F, 5'd1, 5'd2, 5'd15,
          1'b0, 5'd0, 32'd0, 32'd0, 32'hFF00, 5'd15);
    issue("aluop_sub_wrap", 2'b01, 2'b00, C_SUBR, 32'd3, 32'd5, 32'h0, 5'd1, 5'd2, 5'd16,
          1'b0, 5'd0, 32'd0, 32'hFFFF_FFFE, 32'd5, 5'd16);
    issue("add_wrap", 2'b10, 2'b00, C_RTYPE, 32'hFFFF_FFFF, 32'd2, 32'h20, 5'd1, 5'd2, 5'd17,
          1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 5'd17);
    issue("sra", 2'b10, 2'b00, C_RTYPE, 32'h8000_0000, 32'd4, 32'h03, 5'd1, 5'd2, 5'd18,
          1'b0, 5'd0, 32'd0, sra_exp, 32'd4, 5'd18);
    issue("sll", 2'b10, 2'b00, C_RTYPE, 32'd1, 32'd31, 32'h00, 5'd1, 5'd2, 5'd19,
          1'b0, 5'd0, 32'd0, sll_exp, 32'd31, 5'd19);
    issue("srl", 2'b10, 2'b00, C_RTYPE, 32'h8000_0000, 32'd31, 32'h02, 5'd1, 5'd2, 5'd20,
          1'b0, 5'd0, 32'd0, srl_exp, 32'd31, 5'd20);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #4;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain outstanding=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
